fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/ahmes_pkg.sv | 39 +++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahmes_pkg.sv
// Shared opcode nibbles, fetch state encoding and decode helpers
// for the Ahmes-style 8-bit core.
package ahmes_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JNB = 4'hB;
  localparam logic [3:0] OP_SH  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_OP,
    S_OPW,
    S_ARG,
    S_ARGW,
    S_OUT,
    S_HALT
  } fetch_state_t;

  function automatic logic is_two_byte(
    input logic [7:0] op
  );
    case (op[7:4])
      OP_NOP, OP_NOT,
      OP_SH, OP_HLT: return 1'b0;
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction handshake from fetch
// to the execute stage.
interface fetch_unit_if;

  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       two_byte;

  modport master (
    output instr_valid,
    output opcode,
    output operand,
    output two_byte,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  opcode,
    input  operand,
    input  two_byte,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: reads opcode and optional
// address byte, then holds the instruction until accepted.
module fetch_unit
  import ahmes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         pc_value,
  output logic               pc_inc,
  output logic [7:0]         mem_addr,
  output logic               mem_rd,
  input  logic [7:0]         mem_rdata,
  input  logic               flush,
  fetch_unit_if.master       ins,
  output logic               halted
);

  fetch_state_t state;
  logic [7:0]   opcode_q;
  logic [7:0]   operand_q;
  logic         two_byte_q;
  logic         valid_q;
  logic         halted_q;
  logic         rd_state;
  logic         accept;

  assign rd_state = (state == S_OP)
                 || (state == S_ARG);

  // a flush cycle belongs to the PC load
  assign mem_rd   = rd_state && !flush && !reset;
  assign pc_inc   = mem_rd;
  assign mem_addr = pc_value;

  assign accept = valid_q && ins.instr_ready;

  assign ins.instr_valid = valid_q;
  assign ins.opcode      = opcode_q;
  assign ins.operand     = operand_q;
  assign ins.two_byte    = two_byte_q;
  assign halted          = halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_OP;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      two_byte_q <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else if (flush) begin
      state    <= S_OP;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state)
        S_OP: state <= S_OPW;
        S_OPW: begin
          opcode_q   <= mem_rdata;
          two_byte_q <= is_two_byte(mem_rdata);
          if (is_two_byte(mem_rdata)) begin
            state <= S_ARG;
          end else begin
            operand_q <= 8'h00;
            valid_q   <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_ARG: state <= S_ARGW;
        S_ARGW: begin
          operand_q <= mem_rdata;
          valid_q   <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (accept) begin
            valid_q <= 1'b0;
            if (opcode_q[7:4] == OP_HLT) begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              state <= S_OP;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a PC model and a
// synchronous 256x8 memory.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       ready;
  logic [7:0] pc;
  logic [7:0] load_val;
  logic       pc_inc;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       halted;
  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;
  int n_rd  = 0;
  int n_hs  = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();
  assign bus.instr_ready = ready;

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_value  (pc),
    .pc_inc    (pc_inc),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .flush     (flush),
    .ins       (bus),
    .halted    (halted)
  );

  always @(posedge clk or posedge reset) begin
    if (reset)       pc <= 8'h00;
    else if (flush)  pc <= load_val;
    else if (pc_inc) pc <= pc + 8'h01;
  end

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_rd) n_rd++;
    if (bus.instr_valid && ready) n_hs++;
  end

  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] exp_operand;
    logic       exp_two;
    int         exp_lat;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.instr_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.instr_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic accept_wait(output int cyc);
    int c;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    wait_valid(c);
    cyc = c + 1;
  endtask

  task automatic chk_instr(input string n,
                           input logic [7:0] op,
                           input logic [7:0] arg,
                           input logic two);
    chk({n, "_op"},  bus.opcode,   op);
    chk({n, "_arg"}, bus.operand,  arg);
    chk({n, "_two"}, bus.two_byte, two);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cyc, snap, got, addr, pc_m;
    logic [16:0] held;
    logic        stalled;
    logic [7:0]  b, m_op, m_arg;
    logic        m_two;

    reset = 1'b1; flush = 1'b0;
    ready = 1'b0; load_val = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h20; mem[1] = 8'h80;
    mem[2] = 8'h60; mem[3] = 8'h30;
    mem[4] = 8'h44;
    mem[8'h10] = 8'hE1; mem[8'h11] = 8'hF0;

    @(negedge clk);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_halt",  halted, 0);
    chk("rst_rd",    mem_rd, 0);
    chk("rst_inc",   pc_inc, 0);
    chk_instr("rst", 8'h00, 8'h00, 1'b0);
    reset = 1'b0;

    // first edge after release is the opcode read
    wait_valid(cyc);
    chk("lda_lat", cyc, 4);
    chk_instr("lda", 8'h20, 8'h80, 1'b1);
    chk("lda_pc", pc, 8'h02);

    accept_wait(cyc);
    chk("not_lat", cyc, 3);
    chk_instr("not", 8'h60, 8'h00, 1'b0);
    chk("not_pc", pc, 8'h03);

    snap = n_rd;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {bus.instr_valid, bus.opcode},
          {1'b1, 8'h60});
      chk("stall_rd", mem_rd, 0);
    end
    chk("stall_rd_cnt", n_rd - snap, 0);
    chk("stall_pc", pc, 8'h03);
    snap = n_hs;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("one_hs", n_hs - snap, 1);

    repeat (3) @(negedge clk);
    flush = 1'b1; load_val = 8'h10;
    #1;
    chk("flush_inc", pc_inc, 0);
    chk("flush_rd",  mem_rd, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", bus.instr_valid, 0);
    chk("flush_pc", pc, 8'h10);
    wait_valid(cyc);
    chk("sh_lat", cyc, 2);
    chk_instr("sh", 8'hE1, 8'h00, 1'b0);

    accept_wait(cyc);
    chk_instr("hlt", 8'hF0, 8'h00, 1'b0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("halted", halted, 1);
    chk("halt_valid", bus.instr_valid, 0);
    snap = n_rd;
    repeat (10) @(negedge clk);
    chk("halt_rd_cnt", n_rd - snap, 0);
    chk("halt_hold", halted, 1);
    flush = 1'b1; load_val = 8'h00;
    @(negedge clk);
    flush = 1'b0;
    chk("unhalt", halted, 0);
    wait_valid(cyc);
    chk("resume_lat", cyc, 4);
    chk_instr("resume", 8'h20, 8'h80, 1'b1);

    snap = n_hs;
    ready = 1'b1; flush = 1'b1; load_val = 8'h02;
    @(negedge clk);
    ready = 1'b0; flush = 1'b0;
    chk("fl_hs_cnt", n_hs - snap, 1);
    chk("fl_hs_valid", bus.instr_valid, 0);
    wait_valid(cyc);
    chk_instr("fl_hs", 8'h60, 8'h00, 1'b0);

    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rd",    mem_rd, 0);
    chk("mid_inc",   pc_inc, 0);
    chk("mid_valid", bus.instr_valid, 0);
    chk_instr("mid", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(cyc);
    chk("restart_lat", cyc, 4);
    chk_instr("restart", 8'h20, 8'h80, 1'b1);
    chk("restart_pc", pc, 8'h02);

    v[0]  = '{8'h00, 8'h00, 8'h00, 1'b0, 3};
    v[1]  = '{8'h10, 8'h41, 8'h41, 1'b1, 5};
    v[2]  = '{8'h20, 8'h42, 8'h42, 1'b1, 5};
    v[3]  = '{8'h30, 8'h43, 8'h43, 1'b1, 5};
    v[4]  = '{8'h40, 8'h44, 8'h44, 1'b1, 5};
    v[5]  = '{8'h50, 8'h45, 8'h45, 1'b1, 5};
    v[6]  = '{8'h60, 8'h46, 8'h00, 1'b0, 3};
    v[7]  = '{8'h70, 8'h47, 8'h47, 1'b1, 5};
    v[8]  = '{8'h80, 8'h48, 8'h48, 1'b1, 5};
    v[9]  = '{8'h94, 8'h49, 8'h49, 1'b1, 5};
    v[10] = '{8'hA4, 8'h4A, 8'h4A, 1'b1, 5};
    v[11] = '{8'hB8, 8'h4B, 8'h4B, 1'b1, 5};
    v[12] = '{8'hC0, 8'h4C, 8'h4C, 1'b1, 5};
    v[13] = '{8'hD0, 8'h4D, 8'h4D, 1'b1, 5};
    v[14] = '{8'hE2, 8'h4E, 8'h00, 1'b0, 3};

    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    addr = 0;
    for (int i = 0; i < 15; i++) begin
      mem[addr] = v[i].op;
      addr++;
      if (v[i].exp_two) begin
        mem[addr] = v[i].arg;
        addr++;
      end
    end
    do_reset();
    wait_valid(cyc);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) begin
        accept_wait(cyc);
        chk("tbl_lat", cyc, v[i].exp_lat);
      end
      chk_instr("tbl", v[i].op, v[i].exp_operand, v[i].exp_two);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;

    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hF) b[7:4] = 4'h7;
      mem[i] = (i < 64) ? b : 8'h00;
    end
    do_reset();
    pc_m = 0; got = 0;
    stalled = 1'b0; held = '0;
    for (int c = 0; c < 2000 && got < 20; c++) begin
      if (stalled)
        chk("rnd_hold",
            {bus.instr_valid, bus.opcode, bus.operand, bus.two_byte},
            {1'b1, held});
      if (bus.instr_valid) begin
        ready = 1'($urandom_range(0, 1));
        if (ready) begin
          m_op  = mem[pc_m];
          m_two = !(m_op[7:4] inside {4'h0, 4'h6, 4'hE, 4'hF});
          m_arg = m_two ? mem[(pc_m + 1) % 256] : 8'h00;
          pc_m  = pc_m + (m_two ? 2 : 1);
          chk_instr("rnd", m_op, m_arg, m_two);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {bus.opcode, bus.operand, bus.two_byte};
        end
      end else begin
        ready = 1'($urandom_range(0, 1));
        stalled = 1'b0;
      end
      @(negedge clk);
    end
    ready = 1'b0;
    chk("rnd_count", got, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
